regfile_scoreboard: RTL and testbench



---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_busy_tracker.sv | 50 +++++
 rtl/regfile_scoreboard.sv | 78 +++++++
 tb/tb_regfile_scoreboard.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths, handy types and RV32I ABI register indices for the register file slice.
package regfile_pkg;

    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned REG_DATA_WIDTH = 32;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

    localparam int unsigned ZERO = 0;
    localparam int unsigned T0   = 5;
    localparam int unsigned A0   = 10;
    localparam int unsigned A1   = 11;
    localparam int unsigned T4   = 29;

endpackage

// File: rtl/regfile_busy_tracker.sv
// Per-register pending-write scoreboard: set on accepted issue, cleared on writeback or flush.
// REGFILE_BYPASS_EN lets a same-cycle writeback make its register issue-ready.
module regfile_busy_tracker #(
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      issue_valid,
    input  logic [ADDR_WIDTH-1:0]     issue_rd,
    input  logic                      we,
    input  logic [ADDR_WIDTH-1:0]     wa,
    output logic [2**ADDR_WIDTH-1:0]  busy,
    output logic                      issue_ready
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wb_live;
    logic             issue_go;

    always_comb begin
        wb_live     = we && (wa != '0);
        issue_ready = (issue_rd == '0) || !busy_q[issue_rd];
`ifdef REGFILE_BYPASS_EN
        if (wb_live && (wa == issue_rd)) issue_ready = 1'b1;
`endif
        issue_go = issue_valid && issue_ready;

        // Order matters: writeback clears, a same-cycle issue re-sets, flush wipes all.
        busy_d = busy_q;
        if (wb_live) busy_d[wa] = 1'b0;
        if (issue_go && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
        if (flush) busy_d = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with busy scoreboard and debug mirror for the RV32I decode stage.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned DBG_ADDR   = A0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] AD,
    output logic [NUM_READ*DATA_WIDTH-1:0] RD,
    output logic [NUM_READ-1:0]            RBUSY,
    input  logic [ADDR_WIDTH-1:0]          AD3,
    input  logic                           WE3,
    input  logic [DATA_WIDTH-1:0]          WD3,
    input  logic                           ISSUE_VALID,
    input  logic [ADDR_WIDTH-1:0]          ISSUE_RD,
    output logic                           ISSUE_READY,
    input  logic                           FLUSH,
    output logic [DATA_WIDTH-1:0]          DBG
);

    localparam int unsigned           DEPTH   = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] DBG_IDX = ADDR_WIDTH'(DBG_ADDR);

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic                  wb_live;

    assign wb_live = WE3 && (AD3 != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wb_live) begin
            regs[AD3] <= WD3;
        end
    end

    regfile_busy_tracker #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_busy (
        .clk         (clk),
        .rst         (rst),
        .flush       (FLUSH),
        .issue_valid (ISSUE_VALID),
        .issue_rd    (ISSUE_RD),
        .we          (WE3),
        .wa          (AD3),
        .busy        (busy),
        .issue_ready (ISSUE_READY)
    );

    for (genvar g = 0; g < NUM_READ; g++) begin : g_read
        logic [ADDR_WIDTH-1:0] addr;
        logic                  hit;

        assign addr = AD[g*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
        assign hit = wb_live && (addr == AD3);
`else
        assign hit = 1'b0;
`endif
        // x0 is never written nor marked busy, so no special read case is needed.
        assign RD[g*DATA_WIDTH +: DATA_WIDTH] = hit ? WD3 : regs[addr];
        assign RBUSY[g]                       = hit ? 1'b0 : busy[addr];
    end

`ifdef REGFILE_BYPASS_EN
    assign DBG = (wb_live && (AD3 == DBG_IDX)) ? WD3 : regs[DBG_IDX];
`else
    assign DBG = regs[DBG_IDX];
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven self-checking bench for regfile_scoreboard; expectations adapt to REGFILE_BYPASS_EN.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int unsigned AW = REG_ADDR_WIDTH;
    localparam int unsigned DW = REG_DATA_WIDTH;
    localparam int unsigned NR = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [NR*AW-1:0] AD;
    logic [NR*DW-1:0] RD;
    logic [NR-1:0]    RBUSY;
    logic [AW-1:0]    AD3;
    logic             WE3;
    logic [DW-1:0]    WD3;
    logic             ISSUE_VALID;
    logic [AW-1:0]    ISSUE_RD;
    logic             ISSUE_READY;
    logic             FLUSH;
    logic [DW-1:0]    DBG;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_READ   (NR),
        .DBG_ADDR   (A0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .AD          (AD),
        .RD          (RD),
        .RBUSY       (RBUSY),
        .AD3         (AD3),
        .WE3         (WE3),
        .WD3         (WD3),
        .ISSUE_VALID (ISSUE_VALID),
        .ISSUE_RD    (ISSUE_RD),
        .ISSUE_READY (ISSUE_READY),
        .FLUSH       (FLUSH),
        .DBG         (DBG)
    );

    typedef struct {
        logic [AW-1:0] ad0;
        logic [AW-1:0] ad1;
        logic          we;
        logic [AW-1:0] ad3;
        logic [DW-1:0] wd3;
        logic          iv;
        logic [AW-1:0] ird;
        logic          fl;
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        logic [1:0]    rbusy;
        logic          ready;
        logic [DW-1:0] dbg;
    } vec_t;

    typedef struct {
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        logic [1:0]    rbusy;
        logic          ready;
        logic [DW-1:0] dbg;
    } exp_t;

    vec_t vecs [$];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(int ad0, int ad1, bit we, int ad3, logic [DW-1:0] wd3,
                                bit iv, int ird, bit fl, logic [DW-1:0] rd0,
                                logic [DW-1:0] rd1, logic [1:0] rbusy, bit ready,
                                logic [DW-1:0] dbg);
        vec_t v;
        v.ad0 = AW'(ad0); v.ad1 = AW'(ad1); v.we = we; v.ad3 = AW'(ad3); v.wd3 = wd3;
        v.iv = iv; v.ird = AW'(ird); v.fl = fl; v.rd0 = rd0; v.rd1 = rd1;
        v.rbusy = rbusy; v.ready = ready; v.dbg = dbg;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        AD = '0; AD3 = '0; WE3 = 1'b0; WD3 = '0;
        ISSUE_VALID = 1'b0; ISSUE_RD = '0; FLUSH = 1'b0;
    endtask

    initial begin
        exp_t e;
        vec_t v;

        // Each row: inputs held for one cycle, outputs expected just before that cycle's edge.
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
        vecs.push_back(mk(5, 0, 1, 5, 32'h1234, 0, 0, 0, BYP ? 32'h1234 : 32'h0, 0, 2'b00, 1, 0));
        vecs.push_back(mk(5, 0, 1, 0, 32'hDEADBEEF, 1, 0, 0, 32'h1234, 0, 2'b00, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 10, 0, 0, 0, 2'b00, 1, 0));
        vecs.push_back(mk(10, 5, 0, 0, 0, 1, 10, 0, 0, 32'h1234, 2'b01, 0, 0));
        vecs.push_back(mk(10, 5, 1, 10, 32'h55, 0, 10, 0, BYP ? 32'h55 : 32'h0, 32'h1234,
                          BYP ? 2'b00 : 2'b01, BYP, BYP ? 32'h55 : 32'h0));
        vecs.push_back(mk(10, 5, 0, 0, 0, 0, 10, 0, 32'h55, 32'h1234, 2'b00, 1, 32'h55));
        vecs.push_back(mk(7, 10, 1, 7, 32'h77, 1, 7, 0, BYP ? 32'h77 : 32'h0, 32'h55, 2'b00, 1, 32'h55));
        vecs.push_back(mk(7, 3, 0, 0, 0, 1, 3, 0, 32'h77, 0, 2'b01, 1, 32'h55));
        vecs.push_back(mk(3, 9, 0, 0, 0, 1, 9, 0, 0, 0, 2'b01, 1, 32'h55));
        vecs.push_back(mk(3, 9, 0, 0, 0, 1, 4, 1, 0, 0, 2'b11, 1, 32'h55));
        vecs.push_back(mk(4, 7, 0, 0, 0, 0, 7, 0, 0, 32'h77, 2'b00, 1, 32'h55));
        vecs.push_back(mk(3, 12, 1, 12, 32'hA5A5A5A5, 0, 0, 0, 0, BYP ? 32'hA5A5A5A5 : 32'h0,
                          2'b00, 1, 32'h55));
        vecs.push_back(mk(3, 12, 0, 0, 0, 0, 0, 0, 0, 32'hA5A5A5A5, 2'b00, 1, 32'h55));

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            v = vecs[i];
            AD = {v.ad1, v.ad0};
            WE3 = v.we; AD3 = v.ad3; WD3 = v.wd3;
            ISSUE_VALID = v.iv; ISSUE_RD = v.ird; FLUSH = v.fl;
            sb.push_back('{rd0: v.rd0, rd1: v.rd1, rbusy: v.rbusy, ready: v.ready, dbg: v.dbg});
            #2;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL row%0d: scoreboard empty", i);
            end else begin
                e = sb.pop_front();
                check($sformatf("row%0d_rd0", i), RD[DW-1:0], e.rd0);
                check($sformatf("row%0d_rd1", i), RD[2*DW-1:DW], e.rd1);
                check($sformatf("row%0d_rbusy", i), DW'(RBUSY), DW'(e.rbusy));
                check($sformatf("row%0d_ready", i), DW'(ISSUE_READY), DW'(e.ready));
                check($sformatf("row%0d_dbg", i), DBG, e.dbg);
            end
        end

        // Asynchronous reset in the middle of a low phase, with x5 pending.
        @(negedge clk);
        idle_inputs();
        AD = {AW'(10), AW'(5)};
        ISSUE_VALID = 1'b1; ISSUE_RD = AW'(5);
        @(negedge clk);
        ISSUE_VALID = 1'b0;
        #1;
        check("pre_rst_rbusy", DW'(RBUSY), DW'(2'b01));
        check("pre_rst_rd0", RD[DW-1:0], 32'h1234);
        check("pre_rst_ready", DW'(ISSUE_READY), DW'(1'b0));
        check("pre_rst_dbg", DBG, 32'h55);
        #1;
        rst = 1'b1;
        #1;
        check("rst_rd0", RD[DW-1:0], 32'h0);
        check("rst_rd1", RD[2*DW-1:DW], 32'h0);
        check("rst_rbusy", DW'(RBUSY), DW'(2'b00));
        check("rst_ready", DW'(ISSUE_READY), DW'(1'b1));
        check("rst_dbg", DBG, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_rd0", RD[DW-1:0], 32'h0);
        check("post_rst_rbusy", DW'(RBUSY), DW'(2'b00));

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
